// File: rtl/gram_rat_engine.sv
// Gram-matrix engine: accumulates G = X^T * X over L token rows, optionally zeroes entries
// below their row average, then streams out G * W with ready/valid on every port.
module gram_rat_engine #(
  parameter int DW = 8,
  parameter int L  = 16,
  parameter int D  = 8,
  parameter int OW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [DW-1:0] i_data,
  input  logic          thr_en,
  input  logic          w_valid,
  output logic          w_ready,
  input  logic [DW-1:0] w_data,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [OW-1:0] o_data
);

  localparam int LB  = $clog2(L);
  localparam int DB  = $clog2(D);
  localparam int GW  = 2 * DW + LB;
  localparam int RW  = GW + DW + DB;
  localparam int SW  = GW + DB;
  localparam int RCW = (L > 1) ? LB : 1;
  localparam int XW  = (OW > RW) ? OW : RW;

  localparam logic [2:0] S_LOAD  = 3'd0;
  localparam logic [2:0] S_ACC   = 3'd1;
  localparam logic [2:0] S_THR   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;

  logic [2:0]     state;
  logic [RCW-1:0] r;
  logic [DB-1:0]  c;
  logic [DB-1:0]  wj;
  logic [DB-1:0]  k;
  logic           thr_lat;
  logic [DW-1:0]  row  [D];
  logic [GW-1:0]  g    [D][D];
  logic [RW-1:0]  res  [D];

  logic [GW-1:0]  g_prod  [D][D];
  logic [GW-1:0]  g_thr   [D][D];
  logic [SW-1:0]  row_sum [D];
  logic [GW-1:0]  row_avg [D];
  logic [RW-1:0]  o_prod  [D];
  logic [XW-1:0]  o_ext;

  // Handshake readiness is forced low while reset is asserted.
  assign i_ready = rst_n && (state == S_LOAD);
  assign w_ready = rst_n && (state == S_WAIT);
  assign o_valid = rst_n && (state == S_OUT);

  // Outer product of the buffered row, row sums/averages and the thresholded G.
  always_comb begin
    for (int i = 0; i < D; i++) begin
      row_sum[i] = '0;
      for (int j = 0; j < D; j++) begin
        g_prod[i][j] = GW'(row[i]) * GW'(row[j]);
        row_sum[i]   = row_sum[i] + SW'(g[i][j]);
      end
      row_avg[i] = GW'(row_sum[i] >> DB);
      for (int j = 0; j < D; j++) begin
        if (thr_lat && (g[i][j] < row_avg[i])) begin
          g_thr[i][j] = '0;
        end else begin
          g_thr[i][j] = g[i][j];
        end
      end
      o_prod[i] = RW'(g[i][wj]) * RW'(w_data);
    end
  end

  // Result mux; zero-extended when OW is wider than the internal accumulator.
  always_comb begin
    o_ext = XW'(res[k]);
    if (o_valid) begin
      o_data = o_ext[OW-1:0];
    end else begin
      o_data = '0;
    end
  end

  // Frame sequencer and datapath state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_LOAD;
      r       <= '0;
      c       <= '0;
      wj      <= '0;
      k       <= '0;
      thr_lat <= 1'b0;
      for (int i = 0; i < D; i++) begin
        row[i] <= '0;
        res[i] <= '0;
        for (int j = 0; j < D; j++) g[i][j] <= '0;
      end
    end else begin
      case (state)
        S_LOAD: begin
          if (i_valid && i_ready) begin
            row[c] <= i_data;
            if ((r == '0) && (c == '0)) thr_lat <= thr_en;
            if (c == DB'(D - 1)) begin
              c     <= '0;
              state <= S_ACC;
            end else begin
              c <= c + 1'b1;
            end
          end
        end
        S_ACC: begin
          for (int i = 0; i < D; i++)
            for (int j = 0; j < D; j++) g[i][j] <= g[i][j] + g_prod[i][j];
          if (r == RCW'(L - 1)) begin
            r     <= '0;
            state <= S_THR;
          end else begin
            r     <= r + 1'b1;
            state <= S_LOAD;
          end
        end
        S_THR: begin
          for (int i = 0; i < D; i++)
            for (int j = 0; j < D; j++) g[i][j] <= g_thr[i][j];
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_valid && w_ready) begin
            for (int i = 0; i < D; i++) res[i] <= res[i] + o_prod[i];
            if (wj == DB'(D - 1)) begin
              wj    <= '0;
              state <= S_DRAIN;
            end else begin
              wj <= wj + 1'b1;
            end
          end
        end
        S_DRAIN: state <= S_OUT;
        S_OUT: begin
          if (o_ready) begin
            if (k == DB'(D - 1)) begin
              k     <= '0;
              r     <= '0;
              c     <= '0;
              state <= S_LOAD;
              for (int i = 0; i < D; i++) begin
                res[i] <= '0;
                for (int j = 0; j < D; j++) g[i][j] <= '0;
              end
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_gram_rat_engine.sv
// Self-checking bench for gram_rat_engine: table-driven frames, a random-data frame with
// back-pressure checked against a software model, and a mid-frame synchronous reset.
module tb_gram_rat_engine;

  localparam int DW = 8;
  localparam int L  = 16;
  localparam int D  = 8;
  localparam int OW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid;
  logic          i_ready;
  logic [DW-1:0] i_data;
  logic          thr_en;
  logic          w_valid;
  logic          w_ready;
  logic [DW-1:0] w_data;
  logic          o_valid;
  logic          o_ready = 1'b1;
  logic [OW-1:0] o_data;

  gram_rat_engine #(.DW(DW), .L(L), .D(D), .OW(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data), .thr_en(thr_en),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     xpat;   // 0 ones, 1 ramp j+1, 2 all 255, 3 diagonal of 2
    bit     thr;
    int     wpat;   // 0 ones, 1 all 255, 2 j+1
    longint base;
    bit     scale;  // expected out[i] = base*(i+1) when set, else base
    bit     bubble;
  } vec_t;

  int      n_checks = 0;
  int      n_fail   = 0;
  longint  q[$];
  int      xm [L][D];
  int      wv [D];
  longint  expo [D];
  bit      hold_en  = 1'b0;
  int      hold_cnt = 0;
  int      n_out    = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Output-side driver: three-cycle stall while out[2] is presented.
  always @(posedge clk) begin
    #1;
    if (hold_en && n_out == 2 && hold_cnt < 3) begin
      o_ready  = 1'b0;
      hold_cnt = hold_cnt + 1;
    end else begin
      o_ready = 1'b1;
    end
  end

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (o_valid && o_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", longint'(o_data), -1);
        end else begin
          chk("out_data", longint'(o_data), q.pop_front());
          n_out = n_out + 1;
        end
      end else if (!o_ready && hold_en) begin
        chk("hold_valid", longint'(o_valid), 1);
        if (q.size() > 0) chk("hold_data", longint'(o_data), q[0]);
      end else if (!o_valid) begin
        chk("idle_data_zero", longint'(o_data), 0);
      end
    end
  end

  task automatic fill_x(input int xpat);
    for (int l = 0; l < L; l++)
      for (int j = 0; j < D; j++)
        case (xpat)
          0: xm[l][j] = 1;
          1: xm[l][j] = j + 1;
          2: xm[l][j] = 255;
          3: xm[l][j] = (j == (l % D)) ? 2 : 0;
          default: xm[l][j] = $urandom_range(0, 255);
        endcase
  endtask

  task automatic fill_w(input int wpat);
    for (int j = 0; j < D; j++)
      case (wpat)
        0: wv[j] = 1;
        1: wv[j] = 255;
        2: wv[j] = j + 1;
        default: wv[j] = $urandom_range(0, 255);
      endcase
  endtask

  // Reference: G = X^T X, optional strict row-average threshold, then G*W.
  task automatic model(input bit thr);
    longint g [D][D];
    longint s;
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++) begin
        g[i][j] = 0;
        for (int l = 0; l < L; l++) g[i][j] += longint'(xm[l][i]) * longint'(xm[l][j]);
      end
    for (int i = 0; i < D; i++) begin
      s = 0;
      for (int j = 0; j < D; j++) s += g[i][j];
      s = s / D;
      expo[i] = 0;
      for (int j = 0; j < D; j++)
        if (!(thr && g[i][j] < s)) expo[i] += g[i][j] * longint'(wv[j]);
      expo[i] = expo[i] & 64'h0000_0000_FFFF_FFFF;
    end
  endtask

  task automatic send_x(input bit rnd, input bit thr, input bit bubble);
    int  stalls;
    int  guard;
    bit  done;
    for (int idx = 0; idx < L * D; idx++) begin
      stalls = 0;
      guard  = 0;
      done   = 1'b0;
      i_data = DW'(xm[idx / D][idx % D]);
      thr_en = (idx == 0) ? thr : ~thr;
      while (!done) begin
        i_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rnd) begin
          w_valid = 1'($urandom_range(0, 1));
          w_data  = 8'hA5;
        end
        @(negedge clk);
        done = i_valid && i_ready;
        if (i_valid && !done) stalls++;
        @(posedge clk); #1;
        guard++;
        if (!done && guard > 200) begin
          chk("x_accept_timeout", 0, 1);
          done = 1'b1;
        end
      end
      if (bubble) chk("x_bubble", stalls, (idx % D == 0 && idx > 0) ? 1 : 0);
    end
    i_valid = 1'b0;
    w_valid = 1'b0;
  endtask

  task automatic send_w(input bit rnd, input int nw, input bit timing);
    int stalls;
    int guard;
    bit done;
    for (int j = 0; j < nw; j++) begin
      stalls = 0;
      guard  = 0;
      done   = 1'b0;
      w_data = DW'(wv[j]);
      while (!done) begin
        w_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rnd) begin
          i_valid = 1'($urandom_range(0, 1));
          i_data  = 8'h5A;
        end
        @(negedge clk);
        done = w_valid && w_ready;
        if (w_valid && !done) stalls++;
        @(posedge clk); #1;
        guard++;
        if (!done && guard > 200) begin
          chk("w_accept_timeout", 0, 1);
          done = 1'b1;
        end
      end
      if (timing && j == 0) chk("w_ready_latency", stalls, 2);
    end
    w_valid = 1'b0;
    i_valid = 1'b0;
  endtask

  task automatic finish_frame(input bit timing, input bit rnd);
    int guard;
    if (timing) begin
      @(negedge clk); chk("o_valid_u1", longint'(o_valid), 0);
      @(negedge clk); chk("o_valid_u2", longint'(o_valid), 1);
      @(posedge clk); #1;
    end
    guard = 0;
    while (q.size() > 0 && guard < 300) begin
      if (rnd) begin
        i_valid = 1'($urandom_range(0, 1));
        i_data  = 8'h77;
      end
      @(posedge clk); #2;
      guard++;
    end
    i_valid = 1'b0;
    chk("drain_left", q.size(), 0);
    @(negedge clk); chk("i_ready_after_out", longint'(i_ready), 1);
    chk("outputs_seen", n_out, D);
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input bit rnd, input bit hold, input bit thr, input bit bubble);
    n_out    = 0;
    hold_cnt = 0;
    hold_en  = hold;
    for (int i = 0; i < D; i++) q.push_back(expo[i]);
    send_x(rnd, thr, bubble);
    send_w(rnd, D, !rnd);
    finish_frame(!rnd, rnd);
    hold_en = 1'b0;
  endtask

  task automatic table_expo(input vec_t v);
    for (int i = 0; i < D; i++) expo[i] = v.scale ? v.base * longint'(i + 1) : v.base;
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{xpat: 0, thr: 1'b0, wpat: 0, base: 128,        scale: 1'b0, bubble: 1'b0};
    vecs[1] = '{xpat: 1, thr: 1'b0, wpat: 0, base: 576,        scale: 1'b1, bubble: 1'b0};
    vecs[2] = '{xpat: 1, thr: 1'b1, wpat: 0, base: 416,        scale: 1'b1, bubble: 1'b0};
    vecs[3] = '{xpat: 2, thr: 1'b1, wpat: 1, base: 2122416000, scale: 1'b0, bubble: 1'b0};
    vecs[4] = '{xpat: 3, thr: 1'b1, wpat: 2, base: 8,          scale: 1'b1, bubble: 1'b1};

    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    thr_en  = 1'b0;
    w_valid = 1'b0;
    w_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_i_ready", longint'(i_ready), 0);
    chk("rst_w_ready", longint'(w_ready), 0);
    chk("rst_o_valid", longint'(o_valid), 0);
    chk("rst_o_data",  longint'(o_data),  0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_i_ready", longint'(i_ready), 1);
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) begin
      fill_x(vecs[v].xpat);
      fill_w(vecs[v].wpat);
      table_expo(vecs[v]);
      run_frame(1'b0, 1'b0, vecs[v].thr, vecs[v].bubble);
    end

    // Random data with random valids, illegal pulses and an output stall at k=2.
    fill_x(9);
    fill_w(9);
    model(1'b1);
    run_frame(1'b1, 1'b1, 1'b1, 1'b0);
    fill_x(9);
    fill_w(9);
    model(1'b0);
    run_frame(1'b1, 1'b0, 1'b0, 1'b0);

    // Abort a frame after the third weight, then rerun the uniform frame.
    fill_x(0);
    fill_w(0);
    send_x(1'b0, 1'b0, 1'b0);
    send_w(1'b0, 3, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_i_ready", longint'(i_ready), 0);
    chk("abort_w_ready", longint'(w_ready), 0);
    chk("abort_o_valid", longint'(o_valid), 0);
    chk("abort_o_data",  longint'(o_data),  0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_next_i_ready", longint'(i_ready), 1);
    chk("abort_next_w_ready", longint'(w_ready), 0);
    chk("abort_next_o_valid", longint'(o_valid), 0);
    chk("abort_next_o_data",  longint'(o_data),  0);
    @(posedge clk); #1;
    table_expo(vecs[0]);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
